// File: rtl/gain_sched_pkg.sv
// Shared types and constants for the gain scheduler.
package gain_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    I2F = 2'd0,
    MUL = 2'd1,
    F2I = 2'd2
  } op_t;

  // Float unit opcodes as the custom-instruction unit decodes them.
  localparam logic [2:0] DEF_OP_I2F = 3'd1;
  localparam logic [2:0] DEF_OP_MUL = 3'd0;
  localparam logic [2:0] DEF_OP_F2I = 3'd2;

  // Last WAIT-cycle count before the optional watchdog gives up (255th cycle).
  localparam logic [7:0] WD_LIMIT = 8'd254;

endpackage

// File: rtl/gain_scheduler_fp_op_issue.sv
// Single-operation launcher for the shared float unit.
// Handshake: a one-cycle req loads opcode/operands and raises s2_start for
// exactly one cycle; opcode/operands then stay frozen until the unit returns
// s2_done. done is the qualified s2_done (only while an op is outstanding and
// not in the start cycle itself), so stray done pulses are ignored.
module fp_op_issue
  import gain_sched_pkg::*;
#(
  parameter logic [2:0] IDLE_N = DEF_OP_I2F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        req,
  input  logic [2:0]  req_n,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        s2_done,
  output logic        s2_start,
  output logic [2:0]  s2_n,
  output logic [31:0] s2_dataa,
  output logic [31:0] s2_datab,
  output logic        done
);

  logic pending;

  assign done = pending && !s2_start && s2_done;

  // Launch on req, hold operands while outstanding, retire on done or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_start <= 1'b0;
      s2_n     <= IDLE_N;
      s2_dataa <= '0;
      s2_datab <= '0;
      pending  <= 1'b0;
    end else begin
      s2_start <= 1'b0;
      if (abort) begin
        pending <= 1'b0;
      end else if (req) begin
        s2_start <= 1'b1;
        s2_n     <= req_n;
        s2_dataa <= req_a;
        s2_datab <= req_b;
        pending  <= 1'b1;
      end else if (done) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gain_scheduler.sv
// gain_scheduler: runs int->float, multiply-by-gain, float->int for each of
// NCH channels through one shared float unit, then publishes all results in
// a single cycle. Optional watchdog: define GAIN_SCHED_TIMEOUT_EN.
module gain_scheduler
  import gain_sched_pkg::*;
#(
  parameter int         NCH    = 8,
  parameter logic [2:0] OP_I2F = DEF_OP_I2F,
  parameter logic [2:0] OP_MUL = DEF_OP_MUL,
  parameter logic [2:0] OP_F2I = DEF_OP_F2I
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READY,
  input  logic [32*NCH-1:0] sample_in,
  input  logic [32*NCH-1:0] gain_in,
  output logic [32*NCH-1:0] vol_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic [31:0]       s2_dataa,
  output logic [31:0]       s2_datab,
  output logic [2:0]        s2_n,
  output logic              s2_start,
  input  logic              s2_done,
  input  logic [31:0]       s2_result,
`ifdef GAIN_SCHED_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  state_t          state;
  op_t             op;
  logic [CHW-1:0]  ch;
  logic [CHW-1:0]  ch_next;
  logic [31:0]     sample_r [NCH];
  logic [31:0]     gain_r   [NCH];
  logic [31:0]     result_r [NCH];

  logic            accept;
  logic            op_done;
  logic            abort;
  logic            req;
  logic [2:0]      req_n;
  logic [31:0]     req_a;
  logic [31:0]     req_b;

  assign accept    = (state == IDLE) && READY && !busy;
  assign ch_next   = ch + CHW'(1);
  assign dbg_state = state;

`ifdef GAIN_SCHED_TIMEOUT_EN
  logic [7:0] wd;
  assign abort = (state == WAIT) && !op_done && (wd == WD_LIMIT);
`else
  assign abort = 1'b0;
`endif

  // Next operation is requested in the cycle that ends the previous one, so
  // the ISSUE cycle is the start cycle and the running value never needs a
  // separate accumulator: it is forwarded straight from s2_result.
  always_comb begin
    req   = 1'b0;
    req_n = OP_I2F;
    req_a = '0;
    req_b = '0;
    if (accept) begin
      req   = 1'b1;
      req_a = sample_in[31:0];
    end else if ((state == WAIT) && op_done) begin
      case (op)
        I2F: begin
          req   = 1'b1;
          req_n = OP_MUL;
          req_a = s2_result;
          req_b = gain_r[ch];
        end
        MUL: begin
          req   = 1'b1;
          req_n = OP_F2I;
          req_a = s2_result;
        end
        default: begin
          if (ch != LAST_CH) begin
            req   = 1'b1;
            req_a = sample_r[ch_next];
          end
        end
      endcase
    end
  end

  fp_op_issue #(
    .IDLE_N (OP_I2F)
  ) u_issue (
    .clk      (CLK),
    .rst      (RESET),
    .abort    (abort),
    .req      (req),
    .req_n    (req_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .s2_done  (s2_done),
    .s2_start (s2_start),
    .s2_n     (s2_n),
    .s2_dataa (s2_dataa),
    .s2_datab (s2_datab),
    .done     (op_done)
  );

  // Frame sequencer: latch frame, step (channel, op), commit all results at once.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      op        <= I2F;
      ch        <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      vol_out   <= '0;
      for (int c = 0; c < NCH; c++) begin
        sample_r[c] <= '0;
        gain_r[c]   <= '0;
        result_r[c] <= '0;
      end
`ifdef GAIN_SCHED_TIMEOUT_EN
      wd      <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      // busy stays high through the out_valid cycle, so a frame offered then is dropped too.
      if (READY && ((state != IDLE) || busy)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (accept) begin
            for (int c = 0; c < NCH; c++) begin
              sample_r[c] <= sample_in[32*c +: 32];
              gain_r[c]   <= gain_in[32*c +: 32];
            end
            ch    <= '0;
            op    <= I2F;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef GAIN_SCHED_TIMEOUT_EN
          wd <= '0;
`endif
        end
        WAIT: begin
          if (op_done) begin
            case (op)
              I2F: begin
                op    <= MUL;
                state <= ISSUE;
              end
              MUL: begin
                op    <= F2I;
                state <= ISSUE;
              end
              default: begin
                result_r[ch] <= s2_result;
                if (ch == LAST_CH) begin
                  state <= COMMIT;
                end else begin
                  ch    <= ch_next;
                  op    <= I2F;
                  state <= ISSUE;
                end
              end
            endcase
          end
`ifdef GAIN_SCHED_TIMEOUT_EN
          else if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wd <= wd + 8'd1;
          end
`endif
        end
        COMMIT: begin
          for (int c = 0; c < NCH; c++) vol_out[32*c +: 32] <= result_r[c];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_scheduler.sv
// Bench for gain_scheduler with a behavioural float unit of programmable latency.
module tb_gain_scheduler;
  import gain_sched_pkg::*;

  localparam int NCH = 8;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic              CLK = 1'b0;
  logic              RESET, READY;
  logic [32*NCH-1:0] sample_in, gain_in, vol_out;
  logic              out_valid, busy, overrun;
  logic [31:0]       s2_dataa, s2_datab, s2_result;
  logic [2:0]        s2_n;
  logic              s2_start, s2_done;
  logic [1:0]        dbg_state;
`ifdef GAIN_SCHED_TIMEOUT_EN
  logic              timeout;
`endif

  gain_scheduler #(.NCH(NCH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READY     (READY),
    .sample_in (sample_in),
    .gain_in   (gain_in),
    .vol_out   (vol_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .s2_dataa  (s2_dataa),
    .s2_datab  (s2_datab),
    .s2_n      (s2_n),
    .s2_start  (s2_start),
    .s2_done   (s2_done),
    .s2_result (s2_result),
`ifdef GAIN_SCHED_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

  // ---------------- float unit model ----------------
  function automatic logic [31:0] f_from_real(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real r_from_f(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] f2i(input real r);
    if (r >= 2147483647.0) return 32'h7FFFFFFF;
    if (r <= -2147483648.0) return 32'h80000000;
    if (r >= 0.0) return 32'($rtoi(r + 0.5));
    return -32'($rtoi(-r + 0.5));
  endfunction

  function automatic logic [31:0] fp_compute(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b);
    case (n)
      3'd1:    return f_from_real($itor($signed(a)));
      3'd0:    return f_from_real(r_from_f(a) * r_from_f(b));
      3'd2:    return f2i(r_from_f(a));
      default: return 32'd0;
    endcase
  endfunction

  int unsigned d_lat = 4;
  bit          never_done = 1'b0;
  bit          pend;
  int          age;
  logic [2:0]  cap_n;
  logic [31:0] cap_a, cap_b;
  logic        prev_start;
  int          proto_err = 0;

  always @(posedge CLK) begin
    s2_done <= 1'b0;
    if (RESET) begin
      pend       <= 1'b0;
      age        <= 0;
      prev_start <= 1'b0;
    end else begin
      prev_start <= s2_start;
      if (s2_start && (pend || prev_start)) proto_err <= proto_err + 1;
      if (pend && !s2_start && ((s2_dataa != cap_a) || (s2_datab != cap_b) || (s2_n != cap_n)))
        proto_err <= proto_err + 1;
      if (s2_start && !pend) begin
        cap_n <= s2_n;
        cap_a <= s2_dataa;
        cap_b <= s2_datab;
        if (d_lat == 1 && !never_done) begin
          s2_done   <= 1'b1;
          s2_result <= fp_compute(s2_n, s2_dataa, s2_datab);
        end else begin
          pend <= 1'b1;
          age  <= 1;
        end
      end else if (pend && !never_done) begin
        if (age + 1 == int'(d_lat)) begin
          s2_done   <= 1'b1;
          s2_result <= fp_compute(cap_n, cap_a, cap_b);
          pend      <= 1'b0;
        end else begin
          age <= age + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] smp [NCH];
    logic [31:0] gn  [NCH];
    logic [31:0] res [NCH];
  } vec_t;

  vec_t vecs [3];

  // ---------------- driver tasks ----------------
  task automatic load_vec(input int v);
    for (int c = 0; c < NCH; c++) begin
      sample_in[32*c +: 32] = vecs[v].smp[c];
      gain_in[32*c +: 32]   = vecs[v].gn[c];
      exp_q.push_back(vecs[v].res[c]);
    end
  endtask

  // Offer one frame, optionally a second READY and per-cycle input scrambling;
  // returns the READY->out_valid latency and the number of out_valid pulses.
  task automatic run_frame(input int second_at, input bit scramble, output int lat, output int nvalid);
    int cyc;
    @(posedge CLK); #1;
    READY = 1'b1;
    cyc = 0; lat = -1; nvalid = 0;
    while (cyc < 1000 && lat < 0) begin
      @(posedge CLK); #1;
      cyc++;
      READY = (second_at != 0) && (cyc == second_at);
      if (scramble) begin
        for (int c = 0; c < NCH; c++) begin
          sample_in[32*c +: 32] = $urandom;
          gain_in[32*c +: 32]   = $urandom;
        end
      end
      if (out_valid) begin
        lat = cyc;
        nvalid++;
      end
    end
    READY = 1'b0;
  endtask

  task automatic score_frame(input string tag);
    logic [31:0] e;
    for (int c = 0; c < NCH; c++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_ch%0d", tag, c), vol_out[32*c +: 32], e);
    end
  endtask

  task automatic full_frame(input string tag, input int v, input int second_at, input bit scramble);
    int lat, nv;
    load_vec(v);
    run_frame(second_at, scramble, lat, nv);
    check({tag, "_latency"}, lat, 2 + NCH * 3 * (d_lat + 1));
    check({tag, "_busy_at_valid"}, {31'd0, busy}, 32'd1);
    score_frame(tag);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (out_valid) nv++;
    end
    check({tag, "_valid_pulses"}, nv, 1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc, lat, nv;
    RESET = 1'b1; READY = 1'b0; sample_in = '0; gain_in = '0;

    for (int c = 0; c < NCH; c++) begin
      vecs[0].smp[c] = 32'(c + 1); vecs[0].gn[c] = ONE; vecs[0].res[c] = 32'(c + 1);
      vecs[1].smp[c] = 32'd0;      vecs[1].gn[c] = 32'd0; vecs[1].res[c] = 32'd0;
    end
    vecs[1].smp[0] = 32'd1000;      vecs[1].gn[0] = 32'h3F000000; vecs[1].res[0] = 32'd500;
    vecs[1].smp[7] = 32'hFFFFF830;  vecs[1].gn[7] = 32'h40000000; vecs[1].res[7] = 32'hFFFFF060;
    vecs[2].smp = '{32'hFFFFFFFF, 32'hFFFFFF9C, 32'd123456, 32'd4096,
                    32'd7, 32'h40000000, 32'd3, 32'hFFFFFFF7};
    vecs[2].gn  = '{32'h3F800000, 32'h3E800000, 32'h00000000, 32'hBF800000,
                    32'h40400000, 32'h40800000, 32'h3F000000, 32'h3E800000};
    vecs[2].res = '{32'hFFFFFFFF, 32'hFFFFFFE7, 32'd0, 32'hFFFFF000,
                    32'd21, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE};

    repeat (3) @(posedge CLK);
    #1;
    check("reset_vol_out_lo", vol_out[31:0], 32'd0);
    check("reset_vol_out_hi", vol_out[32*NCH-1 -: 32], 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_s2_start", {31'd0, s2_start}, 32'd0);
    check("reset_s2_n", {29'd0, s2_n}, 32'd1);
    check("reset_s2_dataa", s2_dataa, 32'd0);
    check("reset_s2_datab", s2_datab, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    RESET = 1'b0;

    // table-driven frames, D = 4
    for (int v = 0; v < 3; v++) full_frame($sformatf("vec%0d", v), v, 0, 1'b0);
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // shortest float unit latency
    d_lat = 1;
    full_frame("d1_vec0", 0, 0, 1'b0);
    d_lat = 4;

    // second READY 10 cycles in: dropped, overrun sticky
    full_frame("overrun", 1, 10, 1'b0);
    check("overrun_flag", {31'd0, overrun}, 32'd1);

    // inputs scrambled every cycle after the frame is latched
    full_frame("scramble", 2, 0, 1'b1);

    // reset during the WAIT of channel 3 multiply
    load_vec(0);
    exp_q.delete();
    @(posedge CLK); #1;
    READY = 1'b1;
    for (cyc = 1; cyc <= 52; cyc++) begin
      @(posedge CLK); #1;
      READY = 1'b0;
    end
    check("mid_state_wait", {30'd0, dbg_state}, {30'd0, WAIT});
    check("mid_op_mul", {29'd0, s2_n}, 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_s2_start", {31'd0, s2_start}, 32'd0);
    check("abort_vol_out_lo", vol_out[31:0], 32'd0);
    check("abort_vol_out_hi", vol_out[32*NCH-1 -: 32], 32'd0);
    check("abort_overrun_cleared", {31'd0, overrun}, 32'd0);
    RESET = 1'b0;
    nv = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge CLK); #1;
      if (out_valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    full_frame("recover", 1, 0, 1'b0);

    check("protocol", proto_err, 0);

`ifdef GAIN_SCHED_TIMEOUT_EN
    check("timeout_initial", {31'd0, timeout}, 32'd0);
    never_done = 1'b1;
    load_vec(0);
    exp_q.delete();
    @(posedge CLK); #1;
    READY = 1'b1;
    cyc = 0; lat = -1; nv = 0;
    while (cyc < 400 && lat < 0) begin
      @(posedge CLK); #1;
      cyc++;
      READY = 1'b0;
      if (cyc == 256) check("timeout_not_early", {31'd0, timeout}, 32'd0);
      if (out_valid) nv++;
      if (!busy) lat = cyc;
    end
    check("timeout_busy_drop_cycle", lat, 257);
    check("timeout_flag", {31'd0, timeout}, 32'd1);
    check("timeout_no_valid", nv, 0);
    check("timeout_vol_ch0", vol_out[31:0], vecs[1].res[0]);
    check("timeout_vol_ch7", vol_out[32*7 +: 32], vecs[1].res[7]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
